// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared constants, delay-line flag type and the RGB332 to
//               4-4-4 colour expansion used by the VGA scan-out path.
//               Defaults give 640x480@60 from a 50 MHz memclk reading a
//               320x240 pixel-doubled frame buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int c_CLK_DIV  = 2;
    localparam int c_READ_LAT = 2;

    localparam int c_H_VIS  = 640;
    localparam int c_H_FP   = 16;
    localparam int c_H_SYNC = 96;
    localparam int c_H_BP   = 48;
    localparam int c_V_VIS  = 480;
    localparam int c_V_FP   = 10;
    localparam int c_V_SYNC = 2;
    localparam int c_V_BP   = 33;

    localparam int c_H_TOTAL      = c_H_VIS + c_H_FP + c_H_SYNC + c_H_BP;  // 800
    localparam int c_V_TOTAL      = c_V_VIS + c_V_FP + c_V_SYNC + c_V_BP;  // 525
    localparam int c_H_SYNC_START = c_H_VIS + c_H_FP;                      // 656
    localparam int c_H_SYNC_END   = c_H_SYNC_START + c_H_SYNC - 1;         // 751
    localparam int c_V_SYNC_START = c_V_VIS + c_V_FP;                      // 490
    localparam int c_V_SYNC_END   = c_V_SYNC_START + c_V_SYNC - 1;         // 491

    localparam int c_FB_W   = 320;
    localparam int c_ADDR_W = 17;

    // Counter widths are fixed generously so any timing override fits.
    localparam int c_CNT_W = 12;
    localparam int c_DIV_W = 8;

    // Per-pixel control that must travel alongside the frame-buffer read.
    typedef struct packed {
        logic active;
        logic hs_n;
        logic vs_n;
        logic fstart;
    } scan_flags_t;

    localparam scan_flags_t c_FLAGS_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1, fstart: 1'b0};

    // Replicate the top bits into the new LSBs so full scale maps to 0xF.
    function automatic logic [11:0] rgb332_to_444(input logic [7:0] pix);
        return {pix[7:5], pix[7], pix[4:2], pix[4], pix[1:0], pix[1:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_scanout_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_scanout_if
// Description : Frame-buffer read port. The scan-out side (master) drives
//               the address; the frame buffer (slave) returns the RGB332
//               byte a fixed number of memclk edges later.
//   vgactl_addr : frame-buffer read address
//   vgactl_dat  : RGB332 pixel, R[7:5] G[4:2] B[1:0]
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_scanout_if #(
    parameter int ADDR_W = 17
);
    logic [ADDR_W-1:0] vgactl_addr;
    logic [7:0]        vgactl_dat;

    modport master (output vgactl_addr, input  vgactl_dat);
    modport slave  (input  vgactl_addr, output vgactl_dat);
endinterface
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing
// Description : Pixel-clock enable and horizontal/vertical raster counters.
//   memclk, rst   : clock, synchronous active-low reset
//   tick          : last memclk of the current pixel
//   pix_start     : first memclk of the current pixel
//   h_cnt, v_cnt  : current raster position
//   h_nxt, v_nxt  : position after the coming edge (equal to current
//                   unless tick is high)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV = c_CLK_DIV,
    parameter int H_TOTAL = c_H_TOTAL,
    parameter int V_TOTAL = c_V_TOTAL
) (
    input  wire logic               memclk,
    input  wire logic               rst,
    output logic                    tick,
    output logic                    pix_start,
    output logic [c_CNT_W-1:0]      h_cnt,
    output logic [c_CNT_W-1:0]      v_cnt,
    output logic [c_CNT_W-1:0]      h_nxt,
    output logic [c_CNT_W-1:0]      v_nxt
);

    logic [c_DIV_W-1:0] r_div;
    logic [c_CNT_W-1:0] r_h;
    logic [c_CNT_W-1:0] r_v;
    logic               w_h_wrap;

    assign tick      = (r_div == c_DIV_W'(CLK_DIV - 1));
    assign pix_start = (r_div == '0);
    assign w_h_wrap  = tick && (r_h == c_CNT_W'(H_TOTAL - 1));

    always_comb begin
        h_nxt = r_h;
        v_nxt = r_v;
        if (tick) begin
            h_nxt = w_h_wrap ? '0 : r_h + 1'b1;
        end
        if (w_h_wrap) begin
            v_nxt = (r_v == c_CNT_W'(V_TOTAL - 1)) ? '0 : r_v + 1'b1;
        end
    end

    always_ff @(posedge memclk) begin
        if (!rst) begin
            r_div <= '0;
            r_h   <= '0;
            r_v   <= '0;
        end else begin
            r_div <= tick ? '0 : r_div + 1'b1;
            r_h   <= h_nxt;
            r_v   <= v_nxt;
        end
    end

    assign h_cnt = r_h;
    assign v_cnt = r_v;

endmodule
`default_nettype wire

// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
// Module      : vga_scanout
// Description : Display-side frame-buffer reader. Generates VGA timing,
//               reads a half-resolution frame buffer with pixel and line
//               doubling, and expands RGB332 to 4-4-4 with sync and colour
//               aligned to the frame buffer's fixed read latency.
//   memclk, rst        : clock, synchronous active-low reset
//   fb                 : frame-buffer read port (registered address)
//   vga_hs, vga_vs     : active-low syncs
//   vga_r/g/b          : 4-bit colour, zero outside the visible area
//   frame_start        : one-memclk pulse when pixel (0,0) is presented
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scanout
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = c_CLK_DIV,
    parameter int READ_LAT = c_READ_LAT,
    parameter int H_VIS    = c_H_VIS,
    parameter int H_FP     = c_H_FP,
    parameter int H_SYNC   = c_H_SYNC,
    parameter int H_BP     = c_H_BP,
    parameter int V_VIS    = c_V_VIS,
    parameter int V_FP     = c_V_FP,
    parameter int V_SYNC   = c_V_SYNC,
    parameter int V_BP     = c_V_BP,
    parameter int FB_W     = c_FB_W,
    parameter int ADDR_W   = c_ADDR_W
) (
    input  wire logic           memclk,
    input  wire logic           rst,
    vga_scanout_if.master       fb,
    output logic                vga_hs,
    output logic                vga_vs,
    output logic [3:0]          vga_r,
    output logic [3:0]          vga_g,
    output logic [3:0]          vga_b,
    output logic                frame_start
);

    localparam int c_H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int c_HS_START = H_VIS + H_FP;
    localparam int c_HS_STOP  = c_HS_START + H_SYNC;
    localparam int c_VS_START = V_VIS + V_FP;
    localparam int c_VS_STOP  = c_VS_START + V_SYNC;

    logic               w_tick;
    logic               w_pix_start;
    logic [c_CNT_W-1:0] w_h, w_v, w_h_nxt, w_v_nxt;

    vga_timing #(
        .CLK_DIV (CLK_DIV),
        .H_TOTAL (c_H_TOT),
        .V_TOTAL (c_V_TOT)
    ) u_timing (
        .memclk    (memclk),
        .rst       (rst),
        .tick      (w_tick),
        .pix_start (w_pix_start),
        .h_cnt     (w_h),
        .v_cnt     (w_v),
        .h_nxt     (w_h_nxt),
        .v_nxt     (w_v_nxt)
    );

    // ------------------------------------------------------------------
    // Address generation. The address register is loaded from the raster
    // position being entered, so it always matches the counters. Each
    // frame-buffer row is shown on two lines, so the row base advances
    // only when leaving an odd visible line.
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] r_line_base;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_base_nxt;
    logic              w_line_end;
    logic              w_act_nxt;

    assign w_line_end = w_tick && (w_h == c_CNT_W'(c_H_TOT - 1));
    assign w_act_nxt  = (w_h_nxt < c_CNT_W'(H_VIS)) && (w_v_nxt < c_CNT_W'(V_VIS));

    always_comb begin
        w_base_nxt = r_line_base;
        if (w_line_end) begin
            if (w_v == c_CNT_W'(c_V_TOT - 1)) begin
                w_base_nxt = '0;
            end else if (w_v[0] && (w_v < c_CNT_W'(V_VIS))) begin
                w_base_nxt = r_line_base + ADDR_W'(FB_W);
            end
        end
    end

    always_ff @(posedge memclk) begin
        if (!rst) begin
            r_line_base <= '0;
            r_addr      <= '0;
        end else begin
            r_line_base <= w_base_nxt;
            r_addr      <= w_act_nxt ? w_base_nxt + ADDR_W'(w_h_nxt >> 1) : '0;
        end
    end

    assign fb.vgactl_addr = r_addr;

    // ------------------------------------------------------------------
    // Flags of the current position, delayed to meet the read data.
    // frame_start qualifies on the first memclk of pixel (0,0) so it is a
    // single pulse although the pixel lasts CLK_DIV cycles.
    // ------------------------------------------------------------------
    scan_flags_t w_flags;
    scan_flags_t r_pipe [READ_LAT];
    scan_flags_t w_dly;

    always_comb begin
        w_flags        = c_FLAGS_IDLE;
        w_flags.active = (w_h < c_CNT_W'(H_VIS)) && (w_v < c_CNT_W'(V_VIS));
        w_flags.hs_n   = !((w_h >= c_CNT_W'(c_HS_START)) && (w_h < c_CNT_W'(c_HS_STOP)));
        w_flags.vs_n   = !((w_v >= c_CNT_W'(c_VS_START)) && (w_v < c_CNT_W'(c_VS_STOP)));
        w_flags.fstart = w_pix_start && (w_h == '0) && (w_v == '0);
    end

    always_ff @(posedge memclk) begin
        if (!rst) begin
            for (int i = 0; i < READ_LAT; i++) begin
                r_pipe[i] <= c_FLAGS_IDLE;
            end
        end else begin
            r_pipe[0] <= w_flags;
            for (int i = 1; i < READ_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_dly = r_pipe[READ_LAT-1];

    // ------------------------------------------------------------------
    // Output register: read data and delayed flags land together.
    // ------------------------------------------------------------------
    always_ff @(posedge memclk) begin
        if (!rst) begin
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            frame_start <= 1'b0;
        end else begin
            vga_hs      <= w_dly.hs_n;
            vga_vs      <= w_dly.vs_n;
            frame_start <= w_dly.fstart;
            if (w_dly.active) begin
                {vga_r, vga_g, vga_b} <= rgb332_to_444(fb.vgactl_dat);
            end else begin
                {vga_r, vga_g, vga_b} <= '0;
            end
        end
    end

endmodule
`default_nettype wire
